// File: rtl/encrypt_reg_ctrl_if.sv
// Register bus between a host and the encryption register slice.
interface encrypt_reg_ctrl_if #(
   parameter int REG_WD  = 16,
   parameter int ADDR_WD = 9
);
   logic               i_wr_en;
   logic               i_rd_en;
   logic [ADDR_WD-1:0] iv_addr;
   logic [REG_WD-1:0]  iv_wr_data;
   logic [REG_WD-1:0]  ov_rd_data;
   logic               o_rd_valid;

   modport master (
      output i_wr_en, i_rd_en, iv_addr, iv_wr_data,
      input  ov_rd_data, o_rd_valid
   );

   modport slave (
      input  i_wr_en, i_rd_en, iv_addr, iv_wr_data,
      output ov_rd_data, o_rd_valid
   );
endinterface

// File: rtl/encrypt_reg_ctrl.sv
// Assembles the 64-bit encryption word from four ordered 16-bit writes, commits it
// atomically, and provides DNA/status readback. ENCRYPT_RD_PROTECT_EN makes the key write-only.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no sequence open; words 1..3 are errors
// ST_COLLECT | word0 seen, waiting for word exp_idx; inactivity timer runs
// ST_COMMIT  | one cycle: staging copied to ov_encrypt_reg, o_commit pulses
module encrypt_reg_ctrl #(
   parameter int                 REG_WD      = 16,
   parameter int                 LONG_REG_WD = 64,
   parameter int                 ADDR_WD     = 9,
   parameter logic [ADDR_WD-1:0] ADDR_BASE   = 9'h040,
   parameter int                 TIMEOUT_CYC = 40000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   encrypt_reg_ctrl_if.slave      bus,
   input  logic [LONG_REG_WD-1:0] iv_dna_reg,
   input  logic                   i_encrypt_state,
   output logic [LONG_REG_WD-1:0] ov_encrypt_reg,
   output logic                   o_commit,
   output logic                   o_seq_error
);

   localparam int                TMR_WD   = $clog2(TIMEOUT_CYC);
   localparam logic [TMR_WD-1:0] TMR_LOAD = TMR_WD'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_COMMIT
   } state_t;

   state_t                 state;
   logic [1:0]             exp_idx;
   logic [TMR_WD-1:0]      tmr;
   logic [LONG_REG_WD-1:0] staging;
   logic [LONG_REG_WD-1:0] dna_snap;

   logic [ADDR_WD-1:0]     offset;
   logic                   in_range;
   logic                   is_key;
   logic [1:0]             key_idx;
   logic                   wr_key;
   logic                   wr_status;
   logic                   in_prog;
   logic                   err_set;
   logic                   err_clr;
   logic [REG_WD-1:0]      rd_mux;

   function automatic logic [REG_WD-1:0] word_of(input logic [LONG_REG_WD-1:0] v,
                                                 input logic [1:0] idx);
      return v[(3 - int'(idx)) * REG_WD +: REG_WD];
   endfunction

   always_comb begin
      offset    = bus.iv_addr - ADDR_BASE;
      in_range  = (bus.iv_addr >= ADDR_BASE) && (offset <= ADDR_WD'(8));
      is_key    = in_range && (offset < ADDR_WD'(4));
      key_idx   = offset[1:0];
      wr_key    = bus.i_wr_en && is_key;
      wr_status = bus.i_wr_en && in_range && (offset == ADDR_WD'(8));
      in_prog   = (state != ST_IDLE);
      err_clr   = wr_status && bus.iv_wr_data[1];
   end

   // Any out-of-order word is an error; a word0 write always restarts cleanly.
   always_comb begin
      err_set = 1'b0;
      if (wr_key && key_idx != 2'd0) begin
         if (state != ST_COLLECT || key_idx != exp_idx)
            err_set = 1'b1;
      end
      if (state == ST_COLLECT && !wr_key && tmr == '0)
         err_set = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         exp_idx        <= 2'd0;
         tmr            <= '0;
         staging        <= '0;
         ov_encrypt_reg <= '0;
         o_commit       <= 1'b0;
         o_seq_error    <= 1'b0;
      end else begin
         o_commit    <= 1'b0;
         o_seq_error <= err_set | (o_seq_error & ~err_clr);

         if (state == ST_COMMIT) begin
            ov_encrypt_reg <= staging;
            o_commit       <= 1'b1;
         end

         if (wr_key && key_idx == 2'd0) begin
            staging <= {bus.iv_wr_data, {(LONG_REG_WD-REG_WD){1'b0}}};
            exp_idx <= 2'd1;
            tmr     <= TMR_LOAD;
            state   <= ST_COLLECT;
         end else begin
            case (state)
               ST_IDLE: state <= ST_IDLE;
               ST_COLLECT: begin
                  if (wr_key) begin
                     if (key_idx == exp_idx) begin
                        staging[(3 - int'(key_idx)) * REG_WD +: REG_WD] <= bus.iv_wr_data;
                        tmr <= TMR_LOAD;
                        if (key_idx == 2'd3)
                           state <= ST_COMMIT;
                        else
                           exp_idx <= exp_idx + 2'd1;
                     end else begin
                        staging <= '0;
                        state   <= ST_IDLE;
                     end
                  end else if (tmr == '0) begin
                     staging <= '0;
                     state   <= ST_IDLE;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               ST_COMMIT: state <= ST_IDLE;
               default:   state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      if (is_key) begin
`ifdef ENCRYPT_RD_PROTECT_EN
         rd_mux = '0;
`else
         rd_mux = word_of(ov_encrypt_reg, key_idx);
`endif
      end else if (offset == ADDR_WD'(4)) begin
         rd_mux = word_of(iv_dna_reg, 2'd0);
      end else if (offset == ADDR_WD'(8)) begin
         rd_mux = {{(REG_WD-3){1'b0}}, in_prog, o_seq_error, i_encrypt_state};
      end else begin
         rd_mux = word_of(dna_snap, key_idx);
      end
   end

   // Offset 4 freezes the DNA so words 5..7 read back from the same sample.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.ov_rd_data <= '0;
         bus.o_rd_valid <= 1'b0;
         dna_snap       <= '0;
      end else begin
         bus.o_rd_valid <= bus.i_rd_en && in_range;
         if (bus.i_rd_en && in_range) begin
            bus.ov_rd_data <= rd_mux;
            if (offset == ADDR_WD'(4))
               dna_snap <= iv_dna_reg;
         end
      end
   end

endmodule
